// File: rtl/fu_wb_cluster.sv
// Writeback cluster: per-FU result FIFOs feeding one round-robin arbitrated ROB writeback register.
// Define FU_WB_BYPASS_EN to let a result reach the output register directly when its FIFO is empty and it wins.

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module fu_wb_cluster #(
  parameter int NUM_FU     = 3,
  parameter int RESQ_DEPTH = 4
) (
  input  logic                              in_clk,
  input  logic                              in_rst,
  input  logic                              in_flush,
  input  logic [NUM_FU-1:0]                 in_fu_valid,
  input  logic [NUM_FU*`GPR_SIZE-1:0]       in_fu_value,
  input  logic [NUM_FU*`ROB_IDX_SIZE-1:0]   in_fu_dst_rob_index,
  input  logic [NUM_FU-1:0]                 in_fu_set_nzcv,
  input  logic [NUM_FU*4-1:0]               in_fu_nzcv,
  output logic [NUM_FU-1:0]                 out_fu_ready,
  input  logic                              in_rob_ready,
  output logic                              out_rob_done,
  output logic [`ROB_IDX_SIZE-1:0]          out_rob_dst_rob_index,
  output logic [`GPR_SIZE-1:0]              out_rob_value,
  output logic                              out_rob_set_nzcv,
  output logic [3:0]                        out_rob_nzcv,
  output logic [$clog2(NUM_FU)-1:0]         out_rob_src_fu
);

  localparam int GW = `GPR_SIZE;
  localparam int RW = `ROB_IDX_SIZE;
  localparam int PW = $clog2(RESQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_FU);

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [GW-1:0] value;
    logic          set_nzcv;
    logic [3:0]    nzcv;
  } entry_t;

  entry_t        mem       [NUM_FU][RESQ_DEPTH];
  logic [PW-1:0] rd_ptr    [NUM_FU];
  logic [PW-1:0] wr_ptr    [NUM_FU];
  logic [CW-1:0] count     [NUM_FU];
  logic [CW-1:0] count_nxt [NUM_FU];
  entry_t        in_entry  [NUM_FU];

  logic [NUM_FU-1:0] ready_q;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] push_eff;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] req;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_nxt;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic [SW:0]   cand_sum;
  logic          have_win;
  logic          win_bypass;
  logic          load_en;
  logic          do_load;
  entry_t        sel;

  logic          out_valid;
  entry_t        out_q;
  logic [SW-1:0] src_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      in_entry[i].idx      = in_fu_dst_rob_index[i*RW +: RW];
      in_entry[i].value    = in_fu_value[i*GW +: GW];
      in_entry[i].set_nzcv = in_fu_set_nzcv[i];
      in_entry[i].nzcv     = in_fu_nzcv[i*4 +: 4];
      nonempty[i]          = (count[i] != '0);
    end
    push = in_fu_valid & ready_q;
`ifdef FU_WB_BYPASS_EN
    req = nonempty | push;
`else
    req = nonempty;
`endif
  end

  // Circular search starting at rr_ptr; the first requesting channel wins.
  always_comb begin
    have_win = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      cand_sum = {1'b0, rr_ptr} + (SW+1)'(off);
      if (cand_sum >= (SW+1)'(NUM_FU))
        cand_sum = cand_sum - (SW+1)'(NUM_FU);
      cand = cand_sum[SW-1:0];
      if (!have_win && req[cand]) begin
        have_win = 1'b1;
        win      = cand;
      end
    end
  end

  always_comb begin
`ifdef FU_WB_BYPASS_EN
    win_bypass = have_win && !nonempty[win];
`else
    win_bypass = 1'b0;
`endif
    sel     = win_bypass ? in_entry[win] : mem[win][rd_ptr[win]];
    load_en = !out_valid || in_rob_ready;
    do_load = load_en && have_win;
    rr_nxt  = (win == SW'(NUM_FU - 1)) ? '0 : win + 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]       = do_load && !win_bypass && (win == SW'(i));
      push_eff[i]  = push[i] && !(do_load && win_bypass && (win == SW'(i)));
      count_nxt[i] = count[i] + CW'(push_eff[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_eff[i])
        mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  // Reset beats flush; flush drops everything buffered but keeps the fairness pointer.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ready_q   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      src_q     <= '0;
    end else if (in_flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ready_q   <= '1;
      out_valid <= 1'b0;
      out_q     <= '0;
      src_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_eff[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]   <= count_nxt[i];
        ready_q[i] <= (count_nxt[i] < CW'(RESQ_DEPTH));
      end
      if (do_load) begin
        out_valid <= 1'b1;
        out_q     <= sel;
        src_q     <= win;
        rr_ptr    <= rr_nxt;
      end else if (out_valid && in_rob_ready) begin
        out_valid <= 1'b0;
        out_q     <= '0;
        src_q     <= '0;
      end
    end
  end

  assign out_fu_ready          = ready_q;
  assign out_rob_done          = out_valid;
  assign out_rob_dst_rob_index = out_q.idx;
  assign out_rob_value         = out_q.value;
  assign out_rob_set_nzcv      = out_q.set_nzcv;
  assign out_rob_nzcv          = out_q.nzcv;
  assign out_rob_src_fu        = src_q;

endmodule
